io_fifo_ctrl: RTL and testbench
===============================

IO_FIFO_CTRL -- requirements
Module: io_fifo_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0100, address of data port; status port at BASE_ADDR+1.
REQ-002 SHALL have parameter DEPTH, default 8, entries per FIFO; power of two, 2..64.
REQ-003 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port reset_bar  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports addr  input  16  CPU address; bus_in  input  16  CPU write data; bus_out  output  16  read data; bus_oe  output  1  bus_out drive enable.
REQ-006 SHALL have ports DI  input  1  CPU device-write strobe; DO  input  1  CPU device-read strobe.
REQ-007 SHALL have ports tx_data  output  16; tx_valid  output  1; tx_ready  input  1  (output consumer handshake).
REQ-008 SHALL have ports rx_data  input  16; rx_valid  input  1; rx_ready  output  1  (input producer handshake).

Function
REQ-009 SHALL decode: data hit = addr==BASE_ADDR; status hit = addr==BASE_ADDR+1; other addresses ignored, bus_oe=0.
REQ-010 SHALL push bus_in into TX FIFO on clk edge when DI and data hit and TX not full.
REQ-011 SHALL, when DI and data hit and TX full, accept the push only if tx_valid&tx_ready same edge (count unchanged); otherwise drop data and set sticky tx_ovf.
REQ-012 SHALL drive tx_valid = TX not empty, tx_data = TX head, combinationally from registered state; pop on edge with tx_valid&tx_ready.
REQ-013 SHALL drive rx_ready = RX not full, or RX full and CPU pop on same edge; push rx_data on rx_valid&rx_ready.
REQ-014 SHALL, while DO and data hit, drive bus_oe=1, bus_out=RX head (16'h0000 if RX empty); pop on edge if RX not empty; read of empty RX sets sticky rx_unf.
REQ-015 SHALL, while DO and status hit, drive bus_oe=1, bus_out = {rx_unf, tx_ovf, rx_count[6:0], tx_count[6:0]}, counts zero-extended to 7 bits.
REQ-016 SHALL clear tx_ovf and rx_unf on DI with status hit (any write value); a new error on the same edge wins.
REQ-017 SHALL treat DI and DO asserted together as DI only; bus_oe=0 in that cycle.
REQ-018 SHALL keep bus_out=0 whenever bus_oe=0; read latency zero (combinational), pop/push effect visible next cycle.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH; simultaneous push+pop on non-empty, non-full FIFO leaves count unchanged.
REQ-020 SHALL pass TX/RX data in order, no reordering or duplication.

Reset
REQ-021 SHALL, on reset_bar low, asynchronously clear pointers, counts, tx_ovf, rx_unf; tx_valid=0, rx_ready=1 (combinational from cleared state), bus_oe=0, bus_out=0.
REQ-022 SHALL discard all FIFO contents on reset mid-transfer; storage array need not be cleared.

Configuration
REQ-023 SHALL, with IO_FIFO_CTRL_OVFCNT_EN defined, add 16-bit saturating drop counter (TX drops + RX underflows) readable at BASE_ADDR+2, cleared by DI to BASE_ADDR+2 or reset.
REQ-024 SHALL, without IO_FIFO_CTRL_OVFCNT_EN, not decode BASE_ADDR+2 (bus_oe=0) and contain no counter logic.

Structure
REQ-025 SHALL place status bit positions, address offsets (DATA=0, STATUS=1, DROPS=2) in package io_fifo_pkg.
REQ-026 SHALL instantiate sub-module io_sync_fifo (parameterised width/depth, push/pop/full/empty/count) twice, TX and RX.

Verification
REQ-027 SHALL verify: reset, then DI to 0x0100 with bus_in=1..8, tx_ready=0 -> status tx_count=8, tx_valid=1, tx_data=1.
REQ-028 SHALL verify: 9th write with TX full, tx_ready=0 -> data dropped, status bit14 (tx_ovf)=1; DI to 0x0101 clears it.
REQ-029 SHALL verify: tx_ready=1 continuously -> tx_data sequence 1..8 one per cycle, then tx_valid=0.
REQ-030 SHALL verify: producer rx_data=0xA5A5 then 0x5A5A, DO at 0x0100 twice -> bus_out 0xA5A5 then 0x5A5A, third read -> 0x0000 and rx_unf=1.
REQ-031 SHALL verify: full TX, DI push and tx_ready same edge -> accepted, tx_count stays 8, no tx_ovf.
REQ-032 SHALL verify: reset_bar pulsed low mid-stream with 3 entries queued -> counts 0, tx_valid=0, flags clear, before next clk edge.

Source files
------------

// File: rtl/io_fifo_pkg.sv
// Register offsets and status-word layout shared by the I/O FIFO controller.
package io_fifo_pkg;

  typedef enum logic [1:0] {
    OFF_DATA   = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_DROPS  = 2'd2
  } reg_off_e;

  localparam int ST_RX_UNF     = 15;
  localparam int ST_TX_OVF     = 14;
  localparam int ST_RX_CNT_LSB = 7;
  localparam int ST_TX_CNT_LSB = 0;
  localparam int ST_CNT_W      = 7;

  function automatic logic [15:0] reg_addr(input logic [15:0] base, input reg_off_e off);
    return base + {14'd0, off};
  endfunction

  function automatic logic [15:0] status_word(input logic rx_unf, input logic tx_ovf,
                                              input logic [ST_CNT_W-1:0] rx_cnt,
                                              input logic [ST_CNT_W-1:0] tx_cnt);
    logic [15:0] w;
    w = '0;
    w[ST_RX_UNF] = rx_unf;
    w[ST_TX_OVF] = tx_ovf;
    w[ST_RX_CNT_LSB +: ST_CNT_W] = rx_cnt;
    w[ST_TX_CNT_LSB +: ST_CNT_W] = tx_cnt;
    return w;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with combinational head; push on a full FIFO is accepted
// only when a pop happens on the same edge.
module io_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_bar,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_fifo_ctrl.sv
// Memory-mapped CPU port in front of a TX and an RX FIFO with sticky error flags.
// Define IO_FIFO_CTRL_OVFCNT_EN to add a saturating drop counter at BASE_ADDR+2.
module io_fifo_ctrl
  import io_fifo_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0100,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset_bar,
  input  logic [15:0] addr,
  input  logic [15:0] bus_in,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  input  logic        DI,
  input  logic        DO,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             data_hit, status_hit, rd_req;
  logic             tx_push, tx_pop, tx_full, tx_empty, tx_drop;
  logic             rx_push, rx_pop, rx_full, rx_empty, rx_unf_evt;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic [15:0]      rx_head;
  logic             tx_ovf, rx_unf, flag_clr;

  assign data_hit   = (addr == reg_addr(BASE_ADDR, OFF_DATA));
  assign status_hit = (addr == reg_addr(BASE_ADDR, OFF_STATUS));
  // A write strobe masks a simultaneous read; reads are also suppressed while in reset.
  assign rd_req     = DO & ~DI & reset_bar;
  assign flag_clr   = DI & status_hit;

  assign tx_valid   = ~tx_empty;
  assign tx_pop     = tx_valid & tx_ready;
  assign tx_push    = DI & data_hit & (~tx_full | tx_pop);
  assign tx_drop    = DI & data_hit & tx_full & ~tx_pop;

  assign rx_pop     = rd_req & data_hit & ~rx_empty;
  assign rx_unf_evt = rd_req & data_hit & rx_empty;
  assign rx_ready   = ~rx_full | rx_pop;
  assign rx_push    = rx_valid & rx_ready;

  io_sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset_bar(reset_bar),
    .push(tx_push), .wdata(bus_in), .pop(tx_pop), .rdata(tx_data),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  io_sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset_bar(reset_bar),
    .push(rx_push), .wdata(rx_data), .pop(rx_pop), .rdata(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Sticky flags: a new error on the clearing edge takes priority over the clear.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_drop)       tx_ovf <= 1'b1;
      else if (flag_clr) tx_ovf <= 1'b0;
      if (rx_unf_evt)    rx_unf <= 1'b1;
      else if (flag_clr) rx_unf <= 1'b0;
    end
  end

`ifdef IO_FIFO_CTRL_OVFCNT_EN
  logic        drops_hit;
  logic [15:0] drop_cnt;

  assign drops_hit = (addr == reg_addr(BASE_ADDR, OFF_DROPS));

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar)                                      drop_cnt <= '0;
    else if (DI & drops_hit)                             drop_cnt <= '0;
    else if ((tx_drop | rx_unf_evt) && drop_cnt != '1)   drop_cnt <= drop_cnt + 1'b1;
  end
`endif

  always_comb begin
    bus_oe  = 1'b0;
    bus_out = '0;
    if (rd_req) begin
      if (data_hit) begin
        bus_oe  = 1'b1;
        bus_out = rx_empty ? 16'h0000 : rx_head;
      end else if (status_hit) begin
        bus_oe  = 1'b1;
        bus_out = status_word(rx_unf, tx_ovf, ST_CNT_W'(rx_count), ST_CNT_W'(tx_count));
      end
`ifdef IO_FIFO_CTRL_OVFCNT_EN
      else if (drops_hit) begin
        bus_oe  = 1'b1;
        bus_out = drop_cnt;
      end
`endif
    end
  end

endmodule

// File: tb/tb_io_fifo_ctrl.sv
// Self-checking bench for io_fifo_ctrl: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_io_fifo_ctrl;

  localparam logic [15:0] BASE  = 16'h0100;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_bar = 1'b0;
  logic [15:0] addr = '0, bus_in = '0, rx_data = '0;
  logic        DI = 1'b0, DO = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [15:0] bus_out, tx_data;
  logic        bus_oe, tx_valid, rx_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  io_fifo_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_bar(reset_bar), .addr(addr), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .DI(DI), .DO(DO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        di, rd;
    logic [15:0] a, bin;
    logic        trdy, rvld;
    logic [15:0] rdat;
    logic        e_oe;
    logic [15:0] e_out;
    logic        e_tv;
    logic [15:0] e_td;
    logic        e_rr;
  } vec_t;

  vec_t vecs[16];

  // Reference model state
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic        m_ovf, m_unf;
  logic [15:0] m_drops;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic di, input logic rd, input logic [15:0] a,
                               input logic [15:0] bin, input logic trdy,
                               input logic rvld, input logic [15:0] rdat);
    DI = di; DO = rd; addr = a; bus_in = bin;
    tx_ready = trdy; rx_valid = rvld; rx_data = rdat;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic stepCycle(input logic di, input logic rd, input logic [15:0] a,
                           input logic [15:0] bin, input logic trdy,
                           input logic rvld, input logic [15:0] rdat);
    applyStimulus(di, rd, a, bin, trdy, rvld, rdat);
    nextCycle();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    reset_bar = 1'b0;
    #3;
    reset_bar = 1'b1;
    nextCycle();
  endtask

  task automatic modelReset();
    txq.delete();
    rxq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_drops = '0;
  endtask

  // Checks the DUT against the model for the current inputs, then advances the model by one edge.
  task automatic modelCycle(input string tag);
    logic        rd, dh, sh, exp_oe, exp_rr, exp_tv, tpop, err;
    logic [15:0] exp_out;
    int          txn, rxn;
`ifdef IO_FIFO_CTRL_OVFCNT_EN
    logic        xh;
    xh = (addr == BASE + 16'd2);
`endif
    txn = txq.size();
    rxn = rxq.size();
    rd  = DO && !DI;
    dh  = (addr == BASE);
    sh  = (addr == BASE + 16'd1);
    exp_oe  = 1'b0;
    exp_out = 16'h0000;
    if (rd && dh) begin
      exp_oe  = 1'b1;
      exp_out = (rxn > 0) ? rxq[0] : 16'h0000;
    end else if (rd && sh) begin
      exp_oe  = 1'b1;
      exp_out = {m_unf, m_ovf, 7'(rxn), 7'(txn)};
    end
`ifdef IO_FIFO_CTRL_OVFCNT_EN
    else if (rd && xh) begin
      exp_oe  = 1'b1;
      exp_out = m_drops;
    end
`endif
    exp_tv = (txn > 0);
    exp_rr = (rxn < DEPTH) || (rd && dh && rxn > 0);
    checkOutput({tag, " bus_oe"},   16'(bus_oe),   16'(exp_oe));
    checkOutput({tag, " bus_out"},  bus_out,       exp_out);
    checkOutput({tag, " tx_valid"}, 16'(tx_valid), 16'(exp_tv));
    if (exp_tv) checkOutput({tag, " tx_data"}, tx_data, txq[0]);
    checkOutput({tag, " rx_ready"}, 16'(rx_ready), 16'(exp_rr));

    err = 1'b0;
    if (DI && sh) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
`ifdef IO_FIFO_CTRL_OVFCNT_EN
    if (DI && xh) m_drops = '0;
`endif
    tpop = exp_tv && tx_ready;
    if (tpop) void'(txq.pop_front());
    if (DI && dh) begin
      if (txn < DEPTH || tpop) txq.push_back(bus_in);
      else begin
        m_ovf = 1'b1;
        err = 1'b1;
      end
    end
    if (rd && dh) begin
      if (rxn > 0) void'(rxq.pop_front());
      else begin
        m_unf = 1'b1;
        err = 1'b1;
      end
    end
    if (rx_valid && exp_rr) rxq.push_back(rx_data);
    if (err && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
  endtask

  initial begin
    // Vector table, applied from a fresh reset; expectations are worked out by hand.
    vecs[0]  = '{0, 1, 16'h0101, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 1};
    vecs[1]  = '{1, 0, 16'h0100, 16'h1111, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1};
    vecs[2]  = '{0, 1, 16'h0101, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 1, 16'h1111, 1};
    vecs[3]  = '{0, 1, 16'h0200, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0000, 1, 16'h1111, 1};
    vecs[4]  = '{0, 1, 16'h0101, 16'h0000, 0, 0, 16'h0000, 1, 16'h0081, 1, 16'h1111, 1};
    vecs[5]  = '{1, 1, 16'h0100, 16'h2222, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1111, 1};
    vecs[6]  = '{0, 1, 16'h0100, 16'h0000, 0, 0, 16'h0000, 1, 16'hBEEF, 1, 16'h1111, 1};
    vecs[7]  = '{0, 1, 16'h0101, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h1111, 1};
    vecs[8]  = '{0, 1, 16'h0100, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h1111, 1};
    vecs[9]  = '{0, 1, 16'h0101, 16'h0000, 0, 0, 16'h0000, 1, 16'h8002, 1, 16'h1111, 1};
    vecs[10] = '{1, 0, 16'h0101, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1111, 1};
    vecs[11] = '{0, 1, 16'h0101, 16'h0000, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h1111, 1};
    vecs[12] = '{0, 1, 16'h0101, 16'h0000, 1, 0, 16'h0000, 1, 16'h0001, 1, 16'h2222, 1};
    vecs[13] = '{0, 1, 16'h0101, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 1};
`ifdef IO_FIFO_CTRL_OVFCNT_EN
    vecs[14] = '{0, 1, 16'h0102, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 1};
`else
    vecs[14] = '{0, 1, 16'h0102, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1};
`endif
    vecs[15] = '{0, 0, 16'h0300, 16'h0000, 0, 1, 16'h0042, 0, 16'h0000, 0, 16'h0000, 1};

    // Outputs while held in reset from time zero
    #2;
    checkOutput("reset tx_valid", 16'(tx_valid), 16'h0000);
    checkOutput("reset rx_ready", 16'(rx_ready), 16'h0001);
    checkOutput("reset bus_oe",   16'(bus_oe),   16'h0000);
    checkOutput("reset bus_out",  bus_out,       16'h0000);

    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].di, vecs[i].rd, vecs[i].a, vecs[i].bin,
                    vecs[i].trdy, vecs[i].rvld, vecs[i].rdat);
      #1;
      checkOutput($sformatf("vec%0d bus_oe", i),   16'(bus_oe),   16'(vecs[i].e_oe));
      checkOutput($sformatf("vec%0d bus_out", i),  bus_out,       vecs[i].e_out);
      checkOutput($sformatf("vec%0d tx_valid", i), 16'(tx_valid), 16'(vecs[i].e_tv));
      if (vecs[i].e_tv) checkOutput($sformatf("vec%0d tx_data", i), tx_data, vecs[i].e_td);
      checkOutput($sformatf("vec%0d rx_ready", i), 16'(rx_ready), 16'(vecs[i].e_rr));
      nextCycle();
    end

    // Fill TX with 1..8 while the consumer stalls
    doReset();
    for (int i = 1; i <= 8; i++) stepCycle(1, 0, BASE, 16'(i), 0, 0, 0);
    applyStimulus(0, 1, BASE + 16'd1, 0, 0, 0, 0);
    #1;
    checkOutput("fill status", bus_out, 16'h0008);
    checkOutput("fill tx_valid", 16'(tx_valid), 16'h0001);
    checkOutput("fill tx_data", tx_data, 16'h0001);
    nextCycle();

    // Ninth write is dropped and raises tx_ovf; a status write clears it
    stepCycle(1, 0, BASE, 16'h0009, 0, 0, 0);
    applyStimulus(0, 1, BASE + 16'd1, 0, 0, 0, 0);
    #1;
    checkOutput("ovf status", bus_out, 16'h4008);
    checkOutput("ovf bit14", 16'(bus_out[14]), 16'h0001);
    nextCycle();
    stepCycle(1, 0, BASE + 16'd1, 16'hFFFF, 0, 0, 0);
    applyStimulus(0, 1, BASE + 16'd1, 0, 0, 0, 0);
    #1;
    checkOutput("ovf cleared", bus_out, 16'h0008);
    nextCycle();

    // Continuous consumer drains 1..8 in order, one per cycle
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 16'h0000, 0, 1, 0, 0);
      #1;
      checkOutput($sformatf("drain%0d tx_valid", i), 16'(tx_valid), 16'h0001);
      checkOutput($sformatf("drain%0d tx_data", i), tx_data, 16'(i));
      nextCycle();
    end
    applyStimulus(0, 0, 16'h0000, 0, 1, 0, 0);
    #1;
    checkOutput("drained tx_valid", 16'(tx_valid), 16'h0000);
    nextCycle();

    // Push into a full TX on the same edge as a pop: accepted without overflow
    for (int i = 1; i <= 8; i++) stepCycle(1, 0, BASE, 16'h0010 + 16'(i), 0, 0, 0);
    applyStimulus(1, 0, BASE, 16'h0099, 1, 0, 0);
    #1;
    checkOutput("fullpush head", tx_data, 16'h0011);
    nextCycle();
    applyStimulus(0, 1, BASE + 16'd1, 0, 0, 0, 0);
    #1;
    checkOutput("fullpush status", bus_out, 16'h0008);
    nextCycle();
    for (int i = 2; i <= 9; i++) begin
      applyStimulus(0, 0, 16'h0000, 0, 1, 0, 0);
      #1;
      checkOutput($sformatf("fullpush order%0d", i), tx_data,
                  (i == 9) ? 16'h0099 : 16'h0010 + 16'(i));
      nextCycle();
    end
    stepCycle(0, 0, 16'h0000, 0, 0, 0, 0);

    // RX path: two producer words, two reads, then an underflow
    stepCycle(0, 0, 16'h0000, 0, 0, 1, 16'hA5A5);
    stepCycle(0, 0, 16'h0000, 0, 0, 1, 16'h5A5A);
    applyStimulus(0, 1, BASE, 0, 0, 0, 0);
    #1;
    checkOutput("rx read1", bus_out, 16'hA5A5);
    checkOutput("rx read1 oe", 16'(bus_oe), 16'h0001);
    nextCycle();
    applyStimulus(0, 1, BASE, 0, 0, 0, 0);
    #1;
    checkOutput("rx read2", bus_out, 16'h5A5A);
    nextCycle();
    applyStimulus(0, 1, BASE, 0, 0, 0, 0);
    #1;
    checkOutput("rx read empty", bus_out, 16'h0000);
    nextCycle();
    applyStimulus(0, 1, BASE + 16'd1, 0, 0, 0, 0);
    #1;
    checkOutput("rx unf status", bus_out, 16'h8000);
    nextCycle();

    // Asynchronous reset mid-stream with entries queued and rx_unf still set
    stepCycle(1, 0, BASE, 16'h0031, 0, 1, 16'h1234);
    stepCycle(1, 0, BASE, 16'h0032, 0, 0, 0);
    stepCycle(1, 0, BASE, 16'h0033, 0, 0, 0);
    applyStimulus(0, 1, BASE + 16'd1, 0, 0, 0, 0);
    #1;
    checkOutput("pre-reset status", bus_out, 16'h8083);
    reset_bar = 1'b0;
    #1;
    checkOutput("in-reset tx_valid", 16'(tx_valid), 16'h0000);
    checkOutput("in-reset rx_ready", 16'(rx_ready), 16'h0001);
    checkOutput("in-reset bus_oe", 16'(bus_oe), 16'h0000);
    checkOutput("in-reset bus_out", bus_out, 16'h0000);
    reset_bar = 1'b1;
    #1;
    checkOutput("post-reset status", bus_out, 16'h0000);
    checkOutput("post-reset tx_valid", 16'(tx_valid), 16'h0000);
    nextCycle();

    // Randomized traffic with varying bias to reach full and empty on both FIFOs
    doReset();
    modelReset();
    for (int c = 0; c < 900; c++) begin
      int          seg, r, p_di, p_do, p_tr, p_rv;
      logic [15:0] a;
      seg = (c / 100) % 3;
      p_di = (seg == 0) ? 70 : (seg == 1) ? 15 : 40;
      p_do = (seg == 0) ? 20 : (seg == 1) ? 70 : 40;
      p_tr = (seg == 0) ? 15 : (seg == 1) ? 80 : 50;
      p_rv = (seg == 0) ? 80 : (seg == 1) ? 15 : 50;
      r = $urandom_range(0, 9);
      if (r < 5)       a = BASE;
      else if (r < 8)  a = BASE + 16'd1;
      else if (r == 8) a = BASE + 16'd2;
      else             a = BASE + 16'd3 + 16'($urandom_range(0, 200));
      applyStimulus($urandom_range(0, 99) < p_di, $urandom_range(0, 99) < p_do, a,
                    16'($urandom), $urandom_range(0, 99) < p_tr,
                    $urandom_range(0, 99) < p_rv, 16'($urandom));
      #1;
      modelCycle($sformatf("rand%0d", c));
      nextCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
